// File: rtl/regfile_sequencer.sv
// Command sequencer for a 4-entry register file: runs one LOADI/ADD/SUB/MOV
// per accepted command in a fixed IDLE -> READ -> WRITE -> DONE cycle.
module regfile_sequencer #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_rd,
    input  logic [ADDR_W-1:0] i_cmd_rs0,
    input  logic [ADDR_W-1:0] i_cmd_rs1,
    input  logic [WIDTH-1:0]  i_cmd_imm,
    output logic [ADDR_W-1:0] o_reg_read_0,
    output logic [ADDR_W-1:0] o_reg_read_1,
    input  logic [WIDTH-1:0]  i_port_read_0,
    input  logic [WIDTH-1:0]  i_port_read_1,
    output logic [ADDR_W-1:0] o_reg_write,
    output logic [WIDTH-1:0]  o_port_write,
    output logic              o_write_enable,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_carry
);

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_MOV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e              state;
    op_e                 op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [WIDTH-1:0]    imm_q;
    logic                carry_q;

    logic [WIDTH:0]      sum_ext;
    logic [WIDTH:0]      diff_ext;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_carry;

    // The ALU works straight off the read ports; its output is only
    // registered at the READ edge, which is the operand capture point.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_result = '0;
        alu_carry  = 1'b0;
        sum_ext    = {1'b0, i_port_read_0} + {1'b0, i_port_read_1};
        diff_ext   = {1'b0, i_port_read_0} - {1'b0, i_port_read_1};
        case (op_q)
            OP_LOADI: alu_result = imm_q;
            OP_MOV:   alu_result = i_port_read_0;
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_result = diff_ext[WIDTH-1:0];
                alu_carry  = diff_ext[WIDTH];
            end
            default: ;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            op_q           <= OP_LOADI;
            rd_q           <= '0;
            imm_q          <= '0;
            carry_q        <= 1'b0;
            o_cmd_ready    <= 1'b1;
            o_reg_read_0   <= '0;
            o_reg_read_1   <= '0;
            o_reg_write    <= '0;
            o_port_write   <= '0;
            o_write_enable <= 1'b0;
            o_done         <= 1'b0;
            o_result       <= '0;
            o_carry        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        op_q         <= op_e'(i_cmd_op);
                        rd_q         <= i_cmd_rd;
                        imm_q        <= i_cmd_imm;
                        o_reg_read_0 <= i_cmd_rs0;
                        o_reg_read_1 <= i_cmd_rs1;
                        o_cmd_ready  <= 1'b0;
                        state        <= S_READ;
                    end
                end
                S_READ: begin
                    o_port_write   <= alu_result;
                    carry_q        <= alu_carry;
                    o_reg_write    <= rd_q;
                    o_write_enable <= 1'b1;
                    state          <= S_WRITE;
                end
                S_WRITE: begin
                    o_write_enable <= 1'b0;
                    o_done         <= 1'b1;
                    o_result       <= o_port_write;
                    o_carry        <= carry_q;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    o_done      <= 1'b0;
                    o_cmd_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: a behavioural register-file model
// predicts every command's result, flag and register contents.
module tb_regfile_sequencer;

    localparam int WIDTH  = 4;
    localparam int ADDR_W = 2;
    localparam int NREGS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd, cmd_rs0, cmd_rs1;
    logic [WIDTH-1:0]  cmd_imm;
    logic [ADDR_W-1:0] reg_read_0, reg_read_1, reg_write;
    logic [WIDTH-1:0]  port_read_0, port_read_1, port_write;
    logic              write_enable, done, carry;
    logic [WIDTH-1:0]  result;

    // Register file the sequencer drives, and the reference model's view of it.
    logic [WIDTH-1:0]  rf [NREGS];
    int                model_rf [NREGS];

    int n_checks = 0;
    int n_errors = 0;
    int n_cmds   = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int accept_q [$];

    regfile_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_rd       (cmd_rd),
        .i_cmd_rs0      (cmd_rs0),
        .i_cmd_rs1      (cmd_rs1),
        .i_cmd_imm      (cmd_imm),
        .o_reg_read_0   (reg_read_0),
        .o_reg_read_1   (reg_read_1),
        .i_port_read_0  (port_read_0),
        .i_port_read_1  (port_read_1),
        .o_reg_write    (reg_write),
        .o_port_write   (port_write),
        .o_write_enable (write_enable),
        .o_done         (done),
        .o_result       (result),
        .o_carry        (carry)
    );

    always #5 clk = ~clk;

    assign port_read_0 = rf[reg_read_0];
    assign port_read_1 = rf[reg_read_1];

    always @(posedge clk) begin
        if (write_enable) rf[reg_write] <= port_write;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && cmd_valid && cmd_ready) accept_q.push_back(cyc);
        if (write_enable) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t, required < 100000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Command semantics from the operation definitions, in plain integer math.
    function automatic void model_op(input int op, input int a, input int b, input int imm,
                                     output int res, output int c);
        int m;
        m = 1 << WIDTH;
        case (op)
            0: begin res = imm;               c = 0;              end
            1: begin res = (a + b) % m;       c = (a + b >= m);   end
            2: begin res = (a - b + m) % m;   c = (a < b);        end
            default: begin res = a;           c = 0;              end
        endcase
    endfunction

    task automatic scramble();
        cmd_op  = 2'($urandom);
        cmd_rd  = ADDR_W'($urandom);
        cmd_rs0 = ADDR_W'($urandom);
        cmd_rs1 = ADDR_W'($urandom);
        cmd_imm = WIDTH'($urandom);
    endtask

    // Entered and left on a negedge while the sequencer is idle.
    task automatic issue(input int op, input int rd, input int rs0, input int rs1,
                         input int imm, input bit hold);
        int waited = 0;
        int er, ec;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_rd    = ADDR_W'(rd);
        cmd_rs0   = ADDR_W'(rs0);
        cmd_rs1   = ADDR_W'(rs1);
        cmd_imm   = WIDTH'(imm);
        while (!cmd_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("ready_idle", 32'(cmd_ready), 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        model_op(op, model_rf[rs0], model_rf[rs1], imm, er, ec);

        @(negedge clk);
        check("read_ready", 32'(cmd_ready), 0);
        check("read_addr0", 32'(reg_read_0), rs0);
        check("read_addr1", 32'(reg_read_1), rs1);
        check("read_we", 32'(write_enable), 0);
        check("read_done", 32'(done), 0);
        cmd_valid = hold;
        scramble();

        @(negedge clk);
        check("write_ready", 32'(cmd_ready), 0);
        check("write_we", 32'(write_enable), 1);
        check("write_addr", 32'(reg_write), rd);
        check("write_data", 32'(port_write), er);
        check("write_done", 32'(done), 0);
        scramble();

        @(negedge clk);
        check("done_ready", 32'(cmd_ready), 0);
        check("done_pulse", 32'(done), 1);
        check("done_we", 32'(write_enable), 0);
        check("done_result", 32'(result), er);
        check("done_carry", 32'(carry), ec);
        model_rf[rd] = er;
        check("rf_contents", 32'(rf[rd]), er);
        scramble();

        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 1);
        check("idle_done", 32'(done), 0);
        check("idle_result_hold", 32'(result), er);
        n_cmds++;
    endtask

    initial begin
        int we0, done0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_we", 32'(write_enable), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_addr", 32'({reg_read_0, reg_read_1, reg_write}), 0);
        check("rst_wdata", 32'(port_write), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LOADI, then ADD with carry-out and SUB with borrow.
        issue(0, 2, 0, 0, 4'hA, 0);
        issue(0, 0, 0, 0, 9, 0);
        issue(0, 1, 0, 0, 8, 0);
        issue(1, 3, 0, 1, 0, 0);
        issue(2, 0, 1, 0, 0, 0);

        // Self-move, then a dependent ADD reading the freshly written value.
        issue(0, 1, 0, 0, 3, 0);
        issue(3, 1, 1, 2, 0, 0);
        issue(1, 2, 1, 1, 0, 0);

        // valid held high across three commands: acceptances 4 cycles apart.
        accept_q.delete();
        issue(1, 0, 1, 2, 0, 1);
        issue(2, 3, 0, 1, 0, 1);
        issue(0, 2, 3, 3, 5, 0);
        check("hold_accepts", accept_q.size(), 3);
        if (accept_q.size() == 3) begin
            check("hold_gap0", accept_q[1] - accept_q[0], 4);
            check("hold_gap1", accept_q[2] - accept_q[1], 4);
        end

        // Reset during READ of an ADD to R3 aborts it without a write.
        issue(0, 3, 0, 0, 5, 0);
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_rd = 2'd3; cmd_rs0 = 2'd0; cmd_rs1 = 2'd1; cmd_imm = '0;
        check("abort_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        we0   = we_cnt;
        done0 = done_cnt;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready_after", 32'(cmd_ready), 1);
        check("abort_we", 32'(write_enable), 0);
        check("abort_done", 32'(done), 0);
        check("abort_result", 32'(result), 0);
        check("abort_carry", 32'(carry), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_we_count", we_cnt, we0);
        check("abort_done_count", done_cnt, done0);
        check("abort_r3", 32'(rf[3]), 5);

        // Equal-operand SUB and a no-carry ADD reaching all ones.
        issue(0, 2, 0, 0, 7, 0);
        issue(0, 3, 0, 0, 7, 0);
        issue(2, 0, 2, 3, 0, 0);
        issue(0, 1, 0, 0, 8, 0);
        issue(1, 0, 2, 1, 0, 0);

        // Randomized commands, with valid randomly held between them.
        for (int i = 0; i < 24; i++) begin
            issue($urandom_range(0, 3), $urandom_range(0, NREGS - 1),
                  $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                  $urandom_range(0, (1 << WIDTH) - 1), (i != 23) && ($urandom_range(0, 1) == 1));
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("total_writes", we_cnt, n_cmds);
        check("total_dones", done_cnt, n_cmds);
        for (int r = 0; r < NREGS; r++) check("final_rf", 32'(rf[r]), model_rf[r]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
